// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_rr
//  Description : N-channel valid/ready stream multiplexer with a registered
//                output stage; fixed-select or round-robin arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [SW:0] c_num_ch = (SW+1)'(N);

    logic [SW-1:0]  r_ptr;
    logic [W-1:0]   r_out_data;
    logic [SW-1:0]  r_out_ch;
    logic           r_out_valid;

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [SW-1:0]  w_rot_idx;
    logic [SW:0]    w_sum;
    logic [SW:0]    w_wrapped;
    logic [SW-1:0]  w_rr_grant;
    logic [SW-1:0]  w_grant;
    logic           w_any;
    logic           w_sel_ok;
    logic           w_load_en;
    logic           w_xfer;
    logic [W-1:0]   w_data;
    logic [SW-1:0]  w_ptr_next;

    // Rotate the valid vector so that bit 0 is the channel at r_ptr; the
    // lowest set bit of the rotated vector is then the round-robin winner.
    assign w_dbl = {in_valid, in_valid} >> r_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_rot_idx = SW'(i);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_rot_idx};
    assign w_wrapped  = (w_sum >= c_num_ch) ? (w_sum - c_num_ch) : w_sum;
    assign w_rr_grant = w_wrapped[SW-1:0];

    assign w_sel_ok  = ({1'b0, sel} < c_num_ch);
    assign w_grant   = mode ? w_rr_grant : sel;
    assign w_any     = mode ? (|in_valid) : w_sel_ok;
    assign w_load_en = !r_out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        w_data   = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SW'(k)) begin
                in_ready[k] = rst_n && w_load_en && w_any;
                w_data      = in_data[k*W +: W];
            end
        end
    end

    assign w_xfer     = |(in_ready & in_valid);
    assign w_ptr_next = (w_grant == SW'(N - 1)) ? '0 : (w_grant + 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_data;
                r_out_ch    <= w_grant;
                r_out_valid <= 1'b1;
                // Fixed-select transfers leave the round-robin pointer alone.
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mux_rr
//  Description : Scoreboard bench for stream_mux_rr (N=8 main, N=6 range).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [47:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic        mode6;
    logic [2:0]  sel6;
    logic [7:0]  out_data6;
    logic [2:0]  out_ch6;
    logic        out_valid6;
    logic        out_ready6;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    stream_mux_rr #(.N(8), .W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.N(6), .W(8)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data6), .in_valid(in_valid6),
        .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
        .out_ch(out_ch6), .out_valid(out_valid6), .out_ready(out_ready6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.ch   = 3'(ch);
        e.data = 8'(8'h10 + ch);
        sb.push_back(e);
    endtask

    // One round-robin cycle: expect channel exp_ch granted and transferred.
    task automatic run_rr(input int exp_ch);
        push(exp_ch);
        @(negedge clk);
        chk("rr_in_ready", 32'(in_ready), 32'(1) << exp_ch);
        tick();
    endtask

    // Scoreboard monitor: every output handshake consumes one expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_word: got ch=%0d data=0x%0h expected none", out_ch, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_ch", 32'(out_ch), 32'(e.ch));
                chk("out_data", 32'(out_data), 32'(e.data));
            end
        end
    end

    initial begin
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 6; k++) in_data6[k*8 +: 8] = 8'(8'h30 + k);
        rst_n      = 1'b0;
        in_valid   = 8'hFF;
        mode       = 1'b0;
        sel        = 3'd0;
        out_ready  = 1'b1;
        in_valid6  = 6'h3F;
        mode6      = 1'b0;
        sel6       = 3'd7;
        out_ready6 = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();

        // Fixed-mode routing, sel=5
        mode     = 1'b0;
        sel      = 3'd5;
        in_valid = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            push(5);
            @(negedge clk);
            chk("fixed_in_ready", 32'(in_ready), 32'h20);
            tick();
        end
        in_valid = 8'h00;
        tick();

        // Round-robin fairness, all channels valid
        mode     = 1'b1;
        in_valid = 8'hFF;
        for (int i = 0; i < 10; i++) run_rr(i % 8);

        // Sparse round robin (ptr=2 here, so channel 7 first, then 1,7,1,7)
        in_valid = 8'h82;
        run_rr(7);
        run_rr(1);
        run_rr(7);
        run_rr(1);
        run_rr(7);
        in_valid = 8'h80;
        for (int i = 0; i < 3; i++) run_rr(7);
        in_valid = 8'h00;
        tick();

        // Backpressure (ptr=0)
        out_ready = 1'b0;
        in_valid  = 8'hFF;
        push(0);
        @(negedge clk);
        chk("bp_first_ready", 32'(in_ready), 32'h01);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_ch", 32'(out_ch), 32'd0);
            chk("bp_out_data", 32'(out_data), 32'h10);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int ch = 1; ch <= 4; ch++) run_rr(ch);
        in_valid  = 8'h00;
        out_ready = 1'b0;

        // Asynchronous reset mid-cycle while a word is held and ptr=5
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_out_ch", 32'(out_ch), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        mode      = 1'b1;
        in_valid  = 8'h28;
        out_ready = 1'b1;
        push(3);
        #1;
        chk("post_rst_grant", 32'(in_ready), 32'h08);
        tick();
        in_valid = 8'h00;
        tick();
        tick();

        // Out-of-range select on the N=6 instance
        @(negedge clk);
        chk("oor_in_ready", 32'(in_ready6), 32'd0);
        chk("oor_out_valid", 32'(out_valid6), 32'd0);
        sel6 = 3'd6;
        #1;
        chk("oor6_in_ready", 32'(in_ready6), 32'd0);
        tick();
        chk("oor6_out_valid", 32'(out_valid6), 32'd0);
        sel6 = 3'd2;
        @(negedge clk);
        chk("n6_in_ready", 32'(in_ready6), 32'h04);
        tick();
        @(negedge clk);
        chk("n6_out_valid", 32'(out_valid6), 32'd1);
        chk("n6_out_ch", 32'(out_ch6), 32'd2);
        chk("n6_out_data", 32'(out_data6), 32'h32);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with a valid/ready handshake on every channel and a registered output stage. Runs in one of two modes, selected at run time. Fixed-select mode routes the channel chosen by `sel`. Round-robin mode arbitrates fairly among all channels holding valid data. It is the sequential, handshaked successor to the team's combinational 8:1 mux and sits between multiple producer blocks and a single consumer.

## Interface
- `N`, default 8: number of input channels, 2..16.
- `W`, default 8: data width per channel, at least 1.
- `SW`, default `$clog2(N)`: select/channel-index width. Derived; do not override.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  N*W  channel k occupies bits [k*W +: W].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready, combinational; one-hot or zero.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SW  channel index used in fixed mode.
- `out_data`  out  W  registered output data.
- `out_ch`  out  SW  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  consumer ready.

## Operation
- `load_en = !out_valid || out_ready`. The output register accepts a new word only when `load_en` is high.
- A transfer on channel k occurs on a rising edge where `in_valid[k] && in_ready[k]`.
- An output transfer occurs on a rising edge where `out_valid && out_ready`.

Fixed mode (`mode`=0):
- `grant = sel`.
- `in_ready[sel] = load_en && (sel < N)`. All other `in_ready` bits are 0.
- If `sel >= N` (possible only when N is not a power of 2), no channel is granted and all `in_ready` bits are 0.

Round-robin mode (`mode`=1):
- An internal pointer `ptr` (SW bits, range 0..N-1) marks the highest-priority channel.
- `grant` is the first k with `in_valid[k]`, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
- `in_ready[grant] = load_en`. All other bits are 0. If no channel is valid, all bits are 0.
- After a transfer on channel g, `ptr <= (g+1) mod N`. The wrap from N-1 goes to 0.
- `ptr` does not change when no transfer occurs.

On an input transfer:
- `out_data <= in_data[g*W +: W]`
- `out_ch <= g`
- `out_valid <= 1`

On an output transfer with no simultaneous input transfer, `out_valid <= 0`.

A simultaneous output transfer and input transfer in the same cycle is legal. The register reloads with the new word and `out_valid` stays 1, which gives full throughput.

While `out_valid && !out_ready`:
- `out_data` and `out_ch` are held stable.
- All `in_ready` bits are 0.

`mode` and `sel` may change on any cycle and take effect combinationally on that cycle's grant. `ptr` keeps its value across mode changes. Fixed-mode transfers do not update `ptr`.

## Timing
- Latency: 1 cycle. A word accepted at edge t is visible on `out_data` with `out_valid`=1 after edge t.
- Throughput: 1 word per cycle when `out_ready` is held high.
- Reset (`rst_n` low): asynchronously sets `out_valid`=0, `out_data`=0, `out_ch`=0 and `ptr`=0.
- While `rst_n` is low, `in_ready` is forced to all zeros.
- Reset asserted mid-stream discards any held word; no transfer completes on that edge.
- First grant after reset in round-robin mode starts from channel 0.
- No combinational path from `in_valid` or `in_data` to `out_valid`, `out_data` or `out_ch`.
- There is a combinational path from `out_ready`, `in_valid`, `mode` and `sel` to `in_ready`.

## Test plan
- **Fixed-mode routing:** N=8, W=8, `mode`=0, `sel`=5, `in_valid`=0xFF, channel k data = 0x10+k, `out_ready`=1. Expect `out_data`=0x15 and `out_ch`=5 on every cycle from the cycle after the first grant, with `in_ready`=0x20.
- **Round-robin fairness:** `mode`=1, all channels valid, `out_ready`=1. Expect `out_ch` sequence 0,1,2,…,7,0,1 on consecutive cycles, one word per cycle.
- **Sparse round robin with wrap:** `in_valid`=0x82 with `ptr`=0. Expect grants 1, 7, 1, 7. Then drop channel 1 so `in_valid`=0x80; expect repeated grants of 7, with `ptr` returning to 0 each time.
- **Backpressure:** hold `out_ready`=0 for 4 cycles while `out_valid`=1. Expect `out_data`/`out_ch` unchanged and `in_ready`=0. Release `out_ready`; expect the next word on the following cycle with no loss or duplication, checked against a scoreboard.
- **Reset mid-operation:** pulse `rst_n` low asynchronously, between clock edges, while `out_valid`=1 and `ptr`=5. Expect `out_valid`=0, `out_data`=0, `out_ch`=0 immediately. After release, the first round-robin grant goes to the lowest valid channel from 0.
- **Out-of-range select:** N=6, `mode`=0, `sel`=7, all channels valid. Expect `in_ready`=0 and `out_valid` remaining 0.
